// File: rtl/var2_pkg.sv
// Shared definitions for the var2 truth-table scanner: FSM states and
// scan constants used by the controller and its testbench.
package var2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  localparam int          N_VEC       = 32;
  localparam logic [31:0] VAR2_GOLDEN = 32'hB0B0B000;

endpackage

// File: rtl/var2_eval.sv
// Pipelined evaluator for the var2 boolean function.
// The result for a vector presented on 'in' appears on 'out' LAT clocks later.
module var2_eval #(
  parameter int LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] in,
  output logic       out
);

  // The function under scan: (v4 | v3) & v2 & (~v1 | v0)
  function automatic logic var2_f(input logic [4:0] v);
    return (v[4] | v[3]) & v[2] & (~v[1] | v[0]);
  endfunction

  logic [LAT-1:0] stage_r;

  // Register the evaluated bit and shift it through the remaining stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= '0;
    end else begin
      stage_r[0] <= var2_f(in);
      for (int i = 1; i < LAT; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign out = stage_r[LAT-1];

endmodule

// File: rtl/var2_scan_ctrl.sv
// Scan controller: walks all 32 input vectors through the var2 evaluator,
// builds the truth table, counts ones and compares against a sampled golden table.
module var2_scan_ctrl
  import var2_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] expect_tbl,
  output logic        busy,
  output logic        done,
  output logic [31:0] table_out,
  output logic [5:0]  ones,
  output logic        pass
);

  scan_state_t state_r, state_s;

  logic [4:0]     idx_r;
  logic [7:0]     drain_cnt_r;
  logic [31:0]    exp_r;
  logic [LAT-1:0] tag_vld_r;
  logic [4:0]     tag_idx_r [LAT];

  logic        busy_r, done_r, pass_r;
  logic [31:0] table_r, table_nxt_s;
  logic [5:0]  ones_r, ones_nxt_s;

  logic accept_s, feed_s, flush_s, wr_s, res_s;

  // Only an idle controller takes a start, and a simultaneous abort cancels it
  assign accept_s = (state_r == ST_IDLE) && start && !abort;
  assign feed_s   = (state_r == ST_FEED);
  assign flush_s  = abort && ((state_r == ST_FEED) || (state_r == ST_DRAIN));
  assign wr_s     = tag_vld_r[LAT-1];

  var2_eval #(.LAT(LAT)) u_eval (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (idx_r),
    .out   (res_s)
  );

  // Next-state decode of the scan sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_FEED;
        else          state_s = ST_IDLE;
      end
      ST_FEED: begin
        if (abort)                             state_s = ST_IDLE;
        else if (idx_r == 5'(N_VEC - 1))       state_s = ST_DRAIN;
        else                                   state_s = ST_FEED;
      end
      ST_DRAIN: begin
        if (abort)                             state_s = ST_IDLE;
        else if (drain_cnt_r == 8'(LAT - 1))   state_s = ST_DONE;
        else                                   state_s = ST_DRAIN;
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Merge the tagged evaluator result into the table and the ones count
  always_comb begin
    table_nxt_s = table_r;
    ones_nxt_s  = ones_r;
    if (wr_s) begin
      table_nxt_s[tag_idx_r[LAT-1]] = res_s;
      ones_nxt_s                    = ones_r + {5'd0, res_s};
    end else begin
      table_nxt_s = table_r;
      ones_nxt_s  = ones_r;
    end
  end

  // State register, drain counter and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= 8'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      drain_cnt_r <= (state_r == ST_DRAIN) ? drain_cnt_r + 8'd1 : 8'd0;
      busy_r      <= (state_s == ST_FEED) || (state_s == ST_DRAIN);
      done_r      <= (state_s == ST_DONE);
    end
  end

  // Valid/index tags travel alongside the evaluator so each result finds its slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_r <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_idx_r[i] <= 5'd0;
      end
    end else begin
      if (flush_s) begin
        tag_vld_r <= '0;
      end else begin
        tag_vld_r[0] <= feed_s;
        for (int i = 1; i < LAT; i++) begin
          tag_vld_r[i] <= tag_vld_r[i-1];
        end
      end
      tag_idx_r[0] <= idx_r;
      for (int i = 1; i < LAT; i++) begin
        tag_idx_r[i] <= tag_idx_r[i-1];
      end
    end
  end

  // Scan datapath: vector index, golden capture, result table, count and verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= 5'd0;
      exp_r   <= 32'd0;
      table_r <= 32'd0;
      ones_r  <= 6'd0;
      pass_r  <= 1'b0;
    end else if (accept_s) begin
      idx_r   <= 5'd0;
      exp_r   <= expect_tbl;
      table_r <= 32'd0;
      ones_r  <= 6'd0;
      pass_r  <= 1'b0;
    end else begin
      table_r <= table_nxt_s;
      ones_r  <= ones_nxt_s;
      // The 5-bit index wraps to 0 after 31, but FEED has already been left by then
      idx_r   <= feed_s ? idx_r + 5'd1 : idx_r;
      if (flush_s) begin
        pass_r <= 1'b0;
      end else if (state_s == ST_DONE) begin
        pass_r <= (table_nxt_s == exp_r);
      end else begin
        pass_r <= pass_r;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign table_out = table_r;
  assign ones      = ones_r;
  assign pass      = pass_r;

endmodule

// File: tb/tb_var2_scan_ctrl.sv
// Scoreboard bench for var2_scan_ctrl: stimulus pushes the expected scan
// result, a monitor pops and compares whenever done pulses.
module tb_var2_scan_ctrl;
  import var2_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] expect_tbl = 32'd0;
  logic        busy, done, pass;
  logic [31:0] table_out;
  logic [5:0]  ones;

  typedef struct {
    int          cyc;
    logic [31:0] tbl;
    logic [5:0]  ones;
    logic        pass;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  var2_scan_ctrl #(.LAT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .expect_tbl (expect_tbl),
    .busy       (busy),
    .done       (done),
    .table_out  (table_out),
    .ones       (ones),
    .pass       (pass)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; optionally record the scan result it must produce
  task automatic start_scan(input logic [31:0] tbl, input bit push,
                            input logic [31:0] rtbl, input logic [5:0] rones,
                            input logic rpass);
    exp_t e;
    expect_tbl = tbl;
    start = 1'b1;
    if (push) begin
      e.cyc = cyc + 35; e.tbl = rtbl; e.ones = rones; e.pass = rpass;
      exp_q.push_back(e);
    end
    tick(1);
    start = 1'b0;
    expect_tbl = 32'hFFFF_FFFF;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", budget);
      exp_q.delete();
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cyc %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("table_out", table_out, e.tbl);
        chk("ones", {26'd0, ones}, {26'd0, e.ones});
        chk("pass", {31'd0, pass}, {31'd0, e.pass});
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    // Reset state
    tick(2);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_table", table_out, 32'd0);
    chk("rst_ones", {26'd0, ones}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Golden scan
    start_scan(VAR2_GOLDEN, 1'b1, 32'hB0B0B000, 6'd9, 1'b1);
    wait_sb(60);
    tick(3);

    // Mismatching golden table
    start_scan(32'h0, 1'b1, 32'hB0B0B000, 6'd9, 1'b0);
    wait_sb(60);
    tick(5);
    chk("hold_table", table_out, 32'hB0B0B000);
    chk("hold_ones", {26'd0, ones}, 32'd9);
    chk("hold_pass", {31'd0, pass}, 32'd0);

    // Second start during a scan is ignored
    start_scan(VAR2_GOLDEN, 1'b1, 32'hB0B0B000, 6'd9, 1'b1);
    tick(9);
    start = 1'b1;
    expect_tbl = 32'h0;
    tick(1);
    start = 1'b0;
    wait_sb(60);
    tick(40);
    chk("no_rescan_busy", {31'd0, busy}, 32'd0);

    // Abort during cycle 15: results for indices 0..12 kept
    start_scan(VAR2_GOLDEN, 1'b0, 32'd0, 6'd0, 1'b0);
    tick(14);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_table", table_out, 32'h0000_1000);
    chk("abort_ones", {26'd0, ones}, 32'd1);
    chk("abort_pass", {31'd0, pass}, 32'd0);
    tick(40);
    chk("abort_hold_table", table_out, 32'h0000_1000);

    // Reset mid-scan at cycle 20
    start_scan(VAR2_GOLDEN, 1'b0, 32'd0, 6'd0, 1'b0);
    tick(19);
    chk("pre_reset_table", table_out, 32'h0000_B000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_table", table_out, 32'd0);
    chk("mid_rst_ones", {26'd0, ones}, 32'd0);
    chk("mid_rst_pass", {31'd0, pass}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(50);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Abort and start together in IDLE: start dropped
    abort = 1'b1;
    start = 1'b1;
    expect_tbl = VAR2_GOLDEN;
    tick(1);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_busy", {31'd0, busy}, 32'd0);
    tick(3);
    chk("abort_start_busy2", {31'd0, busy}, 32'd0);
    chk("abort_start_table", table_out, 32'd0);
    start_scan(VAR2_GOLDEN, 1'b1, 32'hB0B0B000, 6'd9, 1'b1);
    wait_sb(60);
    tick(5);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
